// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Multi-cycle multiply/divide execute unit. Shift-add multiply
//               and restoring divide, one result bit per cycle, with a final
//               sign-fixup cycle. Holds the pipeline via o_stallReq while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int                     WORD_W     = 32,
    parameter int                     ALU_SEL_W  = 3,
    parameter int                     ALU_OP_W   = 8,
    parameter logic [ALU_SEL_W-1:0]   SEL_MULDIV = ALU_SEL_W'(2),
    parameter logic [ALU_OP_W-1:0]    OP_MULT    = ALU_OP_W'(0),
    parameter logic [ALU_OP_W-1:0]    OP_MULTU   = ALU_OP_W'(1),
    parameter logic [ALU_OP_W-1:0]    OP_DIV     = ALU_OP_W'(2),
    parameter logic [ALU_OP_W-1:0]    OP_DIVU    = ALU_OP_W'(3)
) (
    input  logic                  clk,
    input  logic                  rst,          // asynchronous, active low
    input  logic [ALU_SEL_W-1:0]  ex_alusel,
    input  logic [ALU_OP_W-1:0]   ex_aluop,
    input  logic [WORD_W-1:0]     ex_srcLeft,
    input  logic [WORD_W-1:0]     ex_srcRight,
    input  logic                  i_flush,
    output logic                  o_stallReq,
    output logic                  o_valid,
    output logic [WORD_W-1:0]     o_hi,
    output logic [WORD_W-1:0]     o_lo
);

    localparam int                CNT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [2*WORD_W-1:0]    r_acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [WORD_W-1:0]      r_opb;      // MUL: |multiplicand|; DIV: |divisor|
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_div;
    logic                   r_neg_res;  // negate product / quotient
    logic                   r_neg_rem;  // negate remainder

    // ---------------------------------------------------------------------
    // Op decode and operand preparation
    // ---------------------------------------------------------------------
    logic w_sel, w_is_mul, w_is_div, w_signed, w_start, w_div_zero;
    logic [WORD_W-1:0] w_abs_l, w_abs_r;

    assign w_sel      = (ex_alusel == SEL_MULDIV);
    assign w_is_mul   = (ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU);
    assign w_is_div   = (ex_aluop == OP_DIV)  || (ex_aluop == OP_DIVU);
    assign w_signed   = (ex_aluop == OP_MULT) || (ex_aluop == OP_DIV);
    // Reset and flush both suppress a start so the stall request stays low.
    assign w_start    = rst && !i_flush && (r_state == S_IDLE) && w_sel && (w_is_mul || w_is_div);
    assign w_div_zero = w_is_div && (ex_srcRight == '0);

    assign w_abs_l = (w_signed && ex_srcLeft[WORD_W-1])  ? -ex_srcLeft  : ex_srcLeft;
    assign w_abs_r = (w_signed && ex_srcRight[WORD_W-1]) ? -ex_srcRight : ex_srcRight;

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
    logic [WORD_W:0]        w_mul_sum;
    logic [2*WORD_W-1:0]    w_mul_step;
    logic [WORD_W:0]        w_div_part;
    logic [WORD_W:0]        w_div_diff;
    logic [2*WORD_W-1:0]    w_div_step;

    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right by one (carry enters the top).
    assign w_mul_sum  = {1'b0, r_acc[2*WORD_W-1:WORD_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WORD_W-1:1]};

    // Shift the next dividend bit into the remainder and try a subtract;
    // the borrow bit decides the quotient bit and whether to restore.
    assign w_div_part = r_acc[2*WORD_W-1:WORD_W-1];
    assign w_div_diff = w_div_part - {1'b0, r_opb};
    assign w_div_step = w_div_diff[WORD_W]
                      ? {w_div_part[WORD_W-1:0], r_acc[WORD_W-2:0], 1'b0}
                      : {w_div_diff[WORD_W-1:0], r_acc[WORD_W-2:0], 1'b1};

    // Sign fixup of the magnitude result
    logic [2*WORD_W-1:0]    w_prod_fix;
    logic [WORD_W-1:0]      w_quo_fix, w_rem_fix;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WORD_W-1:0] : r_acc[WORD_W-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WORD_W-1:WORD_W] : r_acc[2*WORD_W-1:WORD_W];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic with stall/valid outputs
    always_comb begin
        w_state_nxt = r_state;
        o_stallReq  = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    o_stallReq  = 1'b1;
                    w_state_nxt = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                o_stallReq = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_SIGN;
                end
            end
            S_SIGN: begin
                o_stallReq  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Operand latch, iteration, sign fixup and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            o_hi      <= '0;
            o_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_signed && (ex_srcLeft[WORD_W-1] ^ ex_srcRight[WORD_W-1]);
                        r_neg_rem <= w_signed && w_is_div && ex_srcLeft[WORD_W-1];
                        r_opb     <= w_is_div ? w_abs_r : w_abs_l;
                        r_acc     <= {{WORD_W{1'b0}}, (w_is_div ? w_abs_l : w_abs_r)};
                        if (w_div_zero) begin
                            o_hi <= ex_srcLeft;
                            o_lo <= '1;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                end
                S_SIGN: begin
                    if (!i_flush) begin
                        if (r_is_div) begin
                            o_hi <= w_rem_fix;
                            o_lo <= w_quo_fix;
                        end else begin
                            {o_hi, o_lo} <= w_prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit: directed vector
//               table, randomized ops against an arithmetic model, and
//               flush / reset / no-op sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam logic [7:0] OP_MULT  = 8'd0;
    localparam logic [7:0] OP_MULTU = 8'd1;
    localparam logic [7:0] OP_DIV   = 8'd2;
    localparam logic [7:0] OP_DIVU  = 8'd3;

    logic        clk;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_srcLeft;
    logic [31:0] ex_srcRight;
    logic        i_flush;
    logic        o_stallReq;
    logic        o_valid;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    bit          in_done = 1'b0;

    ex_muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_alusel   (ex_alusel),
        .ex_aluop    (ex_aluop),
        .ex_srcLeft  (ex_srcLeft),
        .ex_srcRight (ex_srcRight),
        .i_flush     (i_flush),
        .o_stallReq  (o_stallReq),
        .o_valid     (o_valid),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result: full product, or truncating quotient with a
    // dividend-signed remainder; divide by zero returns {a, all ones}.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:  r = '0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_alusel   = sel;
        ex_aluop    = op;
        ex_srcLeft  = a;
        ex_srcRight = b;
    endtask

    // Move to the cycle in which the unit is idle and sees the driven op.
    task automatic enter_t();
        if (in_done) begin
            @(negedge clk);
            in_done = 1'b0;
        end
        #1;
    endtask

    // Caller has driven an op; check stall at issue, count cycles to o_valid,
    // and check stall/hold behaviour while busy plus the final result.
    task automatic run_op(input string name, input int exp_lat, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        bit got, stall_ok, hold_ok;
        enter_t();
        check({name, "_stall_issue"}, 64'(o_stallReq), 64'd1);
        lat = 0; got = 1'b0; stall_ok = 1'b1; hold_ok = 1'b1;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (o_valid) got = 1'b1;
            else begin
                if (o_stallReq !== 1'b1) stall_ok = 1'b0;
                if (o_hi !== last_hi || o_lo !== last_lo) hold_ok = 1'b0;
            end
        end
        check({name, "_valid_seen"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_hi"}, 64'(o_hi), 64'(eh));
        check({name, "_lo"}, 64'(o_lo), 64'(el));
        check({name, "_stall_done"}, 64'(o_stallReq), 64'd0);
        if (lat > 1) begin
            check({name, "_stall_busy"}, 64'(stall_ok), 64'd1);
            check({name, "_hold_busy"}, 64'(hold_ok), 64'd1);
        end
        last_hi = eh;
        last_lo = el;
        in_done = got;
        drive(3'd0, 8'd0, 32'd0, 32'd0);
    endtask

    initial begin
        bit ok_stall, ok_valid;
        logic [7:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp;
        int          rsel;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
        vecs[5] = '{OP_DIVU,  32'd10,        32'd3,         32'd1,         32'd3,         34};
        vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};

        rst     = 1'b0;
        i_flush = 1'b0;
        drive(3'd0, 8'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", 64'(o_stallReq), 64'd0);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_hi", 64'(o_hi), 64'd0);
        check("reset_lo", 64'(o_lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors issued back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(3'd2, vecs[i].op, vecs[i].a, vecs[i].b);
            run_op($sformatf("vec%0d", i), vecs[i].lat, vecs[i].hi, vecs[i].lo);
        end

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop  = 8'($urandom_range(0, 3));
            ra   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            rsel = $urandom_range(0, 9);
            if (rsel == 0)     rb = 32'd0;
            else if (rsel < 3) rb = 32'($urandom_range(1, 15));
            else               rb = $urandom;
            exp = model(rop, ra, rb);
            drive(3'd2, rop, ra, rb);
            run_op($sformatf("rnd%0d_op%0d", i, rop), ((rop == OP_DIV || rop == OP_DIVU) && rb == 0) ? 1 : 34,
                   exp[63:32], exp[31:0]);
        end

        // Flush at CALC cnt=10: back to idle, no result, previous hi/lo kept
        drive(3'd2, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        enter_t();
        check("flush_stall_issue", 64'(o_stallReq), 64'd1);
        repeat (11) @(negedge clk);
        i_flush = 1'b1;
        drive(3'd0, 8'd0, 32'd0, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_stall", 64'(o_stallReq), 64'd0);
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_hi", 64'(o_hi), 64'(last_hi));
        check("flush_lo", 64'(o_lo), 64'(last_lo));
        ok_valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_valid !== 1'b0) ok_valid = 1'b0;
        end
        check("flush_no_valid", 64'(ok_valid), 64'd1);

        // Asynchronous reset at CALC cnt=20 clears everything immediately
        drive(3'd2, OP_DIVU, 32'hDEAD_BEEF, 32'd7);
        enter_t();
        repeat (21) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_stall", 64'(o_stallReq), 64'd0);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_hi", 64'(o_hi), 64'd0);
        check("midrst_lo", 64'(o_lo), 64'd0);
        drive(3'd0, 8'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        last_hi = '0;
        last_lo = '0;

        // Recovery after reset
        drive(3'd2, OP_MULTU, 32'd6, 32'd7);
        run_op("post_reset_mul", 34, 32'd0, 32'd42);

        // Unsupported aluop under SEL_MULDIV, and a different alusel
        drive(3'd2, 8'd7, 32'd5, 32'd3);
        enter_t();
        ok_stall = 1'b1; ok_valid = 1'b1;
        repeat (6) begin
            if (o_stallReq !== 1'b0) ok_stall = 1'b0;
            if (o_valid !== 1'b0)    ok_valid = 1'b0;
            @(negedge clk);
            #1;
        end
        check("noop_op7_stall", 64'(ok_stall), 64'd1);
        check("noop_op7_valid", 64'(ok_valid), 64'd1);
        drive(3'd0, OP_MULT, 32'd5, 32'd3);
        ok_stall = 1'b1; ok_valid = 1'b1;
        repeat (6) begin
            #1;
            if (o_stallReq !== 1'b0) ok_stall = 1'b0;
            if (o_valid !== 1'b0)    ok_valid = 1'b0;
            @(negedge clk);
        end
        check("noop_sel_stall", 64'(ok_stall), 64'd1);
        check("noop_sel_valid", 64'(ok_valid), 64'd1);
        check("noop_hi_kept", 64'(o_hi), 64'(last_hi));
        check("noop_lo_kept", 64'(o_lo), 64'(last_lo));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
